ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Multi-cycle control unit for the lab RISC-V datapath (IF/ID/EX/DM/WB stages).
- Consumes the fetched instruction and the ALU zero flag; produces every datapath control strobe plus PC-update controls.
- Replaces bench-driven control decoding, so each instruction steps through FETCH..WB under FSM control.
- Sits between the instruction fetch output and the EX/DM/WB stages and the PC register.

Parameters:
- ICNT_W, 16, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1, 1 = illegal opcode enters HALT; 0 = illegal instruction is retired as a NOP.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ins  in  32  instruction from the fetch stage.
- zero  in  1  ALU zero flag from EX.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  0 = rd2, 1 = immediate.
- Mem2Reg  out  1  write-back select: 0 = ALU result z, 1 = memOut.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCWrite  out  1  one-cycle pulse that loads the next PC.
- PCSrc  out  2  0 = PCp4, 1 = branch target, 2 = jTarget.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- halted  out  1  high while in HALT.
- icount  out  ICNT_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n low):
  - state=FETCH, IR=0, icount=0, halted=0.
  - All strobes 0, op=010, PCSrc=0.
  - Reset asserted mid-instruction aborts that instruction: no PCWrite and no icount increment.
- FETCH: IR captures ins on the clock edge leaving FETCH. Next state is DECODE.
- DECODE: classifies IR[6:0].
  - 0x33 R-type; 0x13 I-ALU; 0x03 load; 0x23 store; 0x63 beq; 0x6F jal.
  - Any other opcode is illegal.
- ALU op decode (from IR):
  - R-type, funct3 000: funct7[5]=0 → add, funct7[5]=1 → sub.
  - R-type, funct3 111 → and; 110 → or; 010 → slt.
  - I-ALU uses the same funct3 map; funct7 is ignored and 000 is always add.
  - Any other funct3 is illegal.
  - load/store/jal → add; beq → sub.
- Outputs are Moore-style, decoded from state plus IR. They are valid from the cycle the state is entered.
- ALUSrc=1 for I-ALU, load, store and jal in EXEC/MEM/WB; 0 otherwise.
- Sequences:
  - R-type / I-ALU: FETCH→DECODE→EXEC→WB. In WB: RegWrite=1, Mem2Reg=0.
  - load: FETCH→DECODE→EXEC→MEM→WB. In MEM: MemRead=1. In WB: MemRead=1, Mem2Reg=1, RegWrite=1.
  - store: FETCH→DECODE→EXEC→MEM. In MEM: MemWrite=1.
  - beq: FETCH→DECODE→EXEC. In EXEC: PCSrc=1 if zero=1, else 0.
  - jal: FETCH→DECODE→EXEC→WB. PCSrc=2 in EXEC and WB. In WB: RegWrite=1.
- Retirement:
  - PCWrite=1 only in the final state of each sequence; the next state is FETCH.
  - icount increments on the same edge. It wraps modulo 2^ICNT_W without stalling.
- Illegal instruction:
  - HALT_ON_ILLEGAL=1: DECODE→HALT. In HALT all strobes are 0, PCWrite=0 and halted=1; only reset exits.
  - HALT_ON_ILLEGAL=0: DECODE asserts PCWrite with PCSrc=0, increments icount, and returns to FETCH.
- The zero flag is sampled only in beq EXEC. In all other states zero is ignored.
- Instruction latency in cycles: R/I/jal/store 4, load 5, beq 3, illegal-NOP 2.

Optional Feature:
- Macro: CTRL_STALL_EN.
- When defined: adds input stall (1 bit).
  - While stall=1 the state, IR and icount hold.
  - All write strobes (RegWrite, MemWrite, PCWrite) are forced to 0.
  - MemRead, ALUSrc, Mem2Reg, op and PCSrc keep their decoded values.
  - Deasserting stall resumes in the same state with full strobes.
  - Stall has no effect in HALT.
- When undefined: no stall port; the FSM advances every cycle.

Test Plan:
- Reset: rst_n low mid-EXEC of an add → next cycle state=0, icount=0, all strobes 0, op=010, no PCWrite pulse.
- add x3,x1,x2 (0x002081B3), then sub (0x402081B3) → 4 cycles each; op=010 then 110; RegWrite=1 only in WB; icount 0→1→2.
- lw (0x0000A183) then sw (0x0030A223) → lw: MemRead in MEM and WB, Mem2Reg=1 in WB, PCWrite in cycle 5; sw: MemWrite=1 only in MEM, RegWrite never set, PCWrite in cycle 4.
- beq (0x00208463) with zero=1 → PCSrc=1 with PCWrite in cycle 3; repeat with zero=0 → PCSrc=0; jal (0x008000EF) → PCSrc=2, RegWrite in WB.
- Illegal word 0xFFFFFFFF with HALT_ON_ILLEGAL=1 → state=7, halted=1, strobes 0 for 20 cycles; with 0 → PCWrite in DECODE, icount+1.
- ICNT_W=2, four adds → icount wraps 3→0; CTRL_STALL_EN: stall=1 for 3 cycles in WB → RegWrite 0 and state held, then 1 cycle with RegWrite=1.

Source files
------------

// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - control bundle between the multi-cycle control FSM and the datapath
//
// Purpose : groups the instruction/flag inputs and every control strobe of
//           ctrl_fsm so the FSM and the datapath share one port.
// Modports: master - the control FSM (consumes ins/zero[/stall], drives strobes)
//           slave  - the datapath side (drives ins/zero[/stall], consumes strobes)
// Signals : ins[31:0], zero, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
//           op[2:0], PCWrite, PCSrc[1:0], state[2:0], halted, icount[ICNT_W-1:0],
//           stall (only when CTRL_STALL_EN is defined)
// Macro   : CTRL_STALL_EN adds the stall input.

interface ctrl_fsm_if #(
  parameter int ICNT_W = 16
) ();

  logic [31:0]       ins;
  logic              zero;
  logic              RegWrite;
  logic              ALUSrc;
  logic              Mem2Reg;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        op;
  logic              PCWrite;
  logic [1:0]        PCSrc;
  logic [2:0]        state;
  logic              halted;
  logic [ICNT_W-1:0] icount;
`ifdef CTRL_STALL_EN
  logic              stall;
`endif

  modport master (
    input  ins, zero,
    output RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
    output op, PCWrite, PCSrc, state, halted, icount
`ifdef CTRL_STALL_EN
    , input stall
`endif
  );

  modport slave (
    output ins, zero,
    input  RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite,
    input  op, PCWrite, PCSrc, state, halted, icount
`ifdef CTRL_STALL_EN
    , output stall
`endif
  );

endinterface

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle control FSM for the lab RISC-V datapath
//
// Purpose : steps each fetched instruction through FETCH/DECODE/EXEC/MEM/WB
//           and produces the datapath strobes, ALU op and PC-update controls.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - ctrl_fsm_if.master (ins, zero in; strobes, op, PCWrite,
//                   PCSrc, state, halted, icount out; stall in if enabled)
// Params  : ICNT_W          - retired-instruction counter width
//           HALT_ON_ILLEGAL - 1: illegal opcode halts, 0: retired as a NOP
// Macro   : CTRL_STALL_EN adds a stall input that freezes the FSM and masks
//           the write strobes.

module ctrl_fsm #(
  parameter int ICNT_W          = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ctrl_fsm_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [ICNT_W-1:0] icount_q, icount_d;

  // Instruction classification from the latched IR
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_r, is_i, is_ld, is_st, is_beq, is_jal;
  logic       f3_ok, legal;
  logic [2:0] alu_op;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7_5 = ir_q[30];

  // Register/immediate fields are consumed by the datapath, not here
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  always_comb begin
    is_r   = (opcode == 7'h33);
    is_i   = (opcode == 7'h13);
    is_ld  = (opcode == 7'h03);
    is_st  = (opcode == 7'h23);
    is_beq = (opcode == 7'h63);
    is_jal = (opcode == 7'h6F);
    alu_op = OP_ADD;
    f3_ok  = 1'b1;
    if (is_r || is_i) begin
      case (funct3)
        // funct7[5] selects sub only for R-type; I-ALU 000 is always addi
        3'b000:  alu_op = (is_r && funct7_5) ? OP_SUB : OP_ADD;
        3'b111:  alu_op = OP_AND;
        3'b110:  alu_op = OP_OR;
        3'b010:  alu_op = OP_SLT;
        default: f3_ok  = 1'b0;
      endcase
    end else if (is_beq) begin
      alu_op = OP_SUB;
    end
    legal = (is_r || is_i || is_ld || is_st || is_beq || is_jal) && f3_ok;
  end

  // Next-state and Moore outputs
  logic       reg_write, alu_src, mem2reg, mem_read, mem_write, pc_write;
  logic [1:0] pc_src;
  logic [2:0] op_o;
  logic       retire;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    icount_d  = icount_q;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem2reg   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    op_o      = OP_ADD;
    retire    = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)
      alu_src = is_i || is_ld || is_st || is_jal;
    // FETCH still holds the previous IR, so op is only decoded once DECODE is reached
    if (state_q != S_FETCH && state_q != S_HALT)
      op_o = alu_op;

    case (state_q)
      S_FETCH: begin
        ir_d    = bus.ins;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (legal)
          state_d = S_EXEC;
        else if (HALT_ON_ILLEGAL)
          state_d = S_HALT;
        else
          retire = 1'b1;
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_src = bus.zero ? 2'd1 : 2'd0;
          retire = 1'b1;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          if (is_jal) pc_src = 2'd2;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_ld) begin
          mem_read = 1'b1;
          state_d  = S_WB;
        end else begin
          mem_write = 1'b1;
          retire    = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_ld) begin
          mem_read = 1'b1;
          mem2reg  = 1'b1;
        end
        if (is_jal) pc_src = 2'd2;
        retire = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Last state of every sequence: load the PC and count the instruction
    if (retire) begin
      pc_write = 1'b1;
      state_d  = S_FETCH;
      icount_d = icount_q + ICNT_W'(1);
    end

`ifdef CTRL_STALL_EN
    // Freeze progress and suppress side effects; read-side controls stay decoded
    if (bus.stall && state_q != S_HALT) begin
      state_d   = state_q;
      ir_d      = ir_q;
      icount_d  = icount_q;
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      ir_q     <= 32'd0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
    end
  end

  assign bus.RegWrite = reg_write;
  assign bus.ALUSrc   = alu_src;
  assign bus.Mem2Reg  = mem2reg;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.op       = op_o;
  assign bus.PCWrite  = pc_write;
  assign bus.PCSrc    = pc_src;
  assign bus.state    = state_q;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.icount   = icount_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - table-driven bench for ctrl_fsm (halting, NOP-on-illegal and 2-bit counter builds)

module tb_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        zero = 1'b0;
`ifdef CTRL_STALL_EN
  logic        stall = 1'b0;
`endif

  always #5 clk = ~clk;

  ctrl_fsm_if #(.ICNT_W(16)) if_m ();
  ctrl_fsm_if #(.ICNT_W(16)) if_n ();
  ctrl_fsm_if #(.ICNT_W(2))  if_w ();

  assign if_m.ins = ins;  assign if_m.zero = zero;
  assign if_n.ins = ins;  assign if_n.zero = zero;
  assign if_w.ins = ins;  assign if_w.zero = zero;
`ifdef CTRL_STALL_EN
  assign if_m.stall = stall;
  assign if_n.stall = stall;
  assign if_w.stall = stall;
`endif

  ctrl_fsm #(.ICNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  ctrl_fsm #(.ICNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n));
  ctrl_fsm #(.ICNT_W(2),  .HALT_ON_ILLEGAL(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w));

  // {state, halted, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, PCWrite, PCSrc, op}
  logic [14:0] act_m, act_n, act_w;
  assign act_m = {if_m.state, if_m.halted, if_m.RegWrite, if_m.ALUSrc, if_m.Mem2Reg,
                  if_m.MemRead, if_m.MemWrite, if_m.PCWrite, if_m.PCSrc, if_m.op};
  assign act_n = {if_n.state, if_n.halted, if_n.RegWrite, if_n.ALUSrc, if_n.Mem2Reg,
                  if_n.MemRead, if_n.MemWrite, if_n.PCWrite, if_n.PCSrc, if_n.op};
  assign act_w = {if_w.state, if_w.halted, if_w.RegWrite, if_w.ALUSrc, if_w.Mem2Reg,
                  if_w.MemRead, if_w.MemWrite, if_w.PCWrite, if_w.PCSrc, if_w.op};

  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3;
  localparam logic [31:0] I_LW  = 32'h0000A183, I_SW  = 32'h0030A223;
  localparam logic [31:0] I_BEQ = 32'h00208463, I_JAL = 32'h008000EF;
  localparam logic [31:0] I_ORI = 32'h4010E093, I_AND = 32'h0020F1B3;
  localparam logic [31:0] I_SLT = 32'h0020A1B3, I_ILL = 32'hFFFFFFFF;

  localparam logic [2:0] OA = 3'b010, OS = 3'b110, ON = 3'b000, OO = 3'b001, OL = 3'b111;

  // strobe bundle: {RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, PCWrite}
  localparam logic [5:0] NONE = 6'b000000, EX_I = 6'b010000, WB_R = 6'b100001;
  localparam logic [5:0] MEM_L = 6'b010100, WB_L = 6'b111101, MEM_S = 6'b010011;
  localparam logic [5:0] WB_J = 6'b110001, RET = 6'b000001;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic [1:0]  pcs;
    logic [2:0]  op;
    logic [15:0] icnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t v(input logic [31:0] i, input logic z, input logic [2:0] st,
                             input logic [5:0] strb, input logic [1:0] pcs,
                             input logic [2:0] op, input logic [15:0] icnt);
    vec_t r;
    r.ins = i; r.zero = z; r.st = st; r.strb = strb; r.pcs = pcs; r.op = op; r.icnt = icnt;
    return r;
  endfunction

  function automatic logic [14:0] pk(input logic [2:0] st, input logic h, input logic [5:0] strb,
                                     input logic [1:0] pcs, input logic [2:0] op);
    return {st, h, strb, pcs, op};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t r, input int idx);
    logic [14:0] e;
    ins  = r.ins;
    zero = r.zero;
    e = pk(r.st, 1'b0, r.strb, r.pcs, r.op);
    @(negedge clk);
    chk("ctl_halt", idx, 32'(act_m), 32'(e));
    chk("ctl_nop",  idx, 32'(act_n), 32'(e));
    chk("ctl_w2",   idx, 32'(act_w), 32'(e));
    chk("icnt_halt", idx, 32'(if_m.icount), 32'(r.icnt));
    chk("icnt_nop",  idx, 32'(if_n.icount), 32'(r.icnt));
    chk("icnt_w2",   idx, 32'(if_w.icount), 32'(r.icnt[1:0]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // add, sub
    vecs.push_back(v(I_ADD,0,0,NONE,0,OA,0)); vecs.push_back(v(I_ADD,0,1,NONE,0,OA,0));
    vecs.push_back(v(I_ADD,0,2,NONE,0,OA,0)); vecs.push_back(v(I_ADD,0,4,WB_R,0,OA,0));
    vecs.push_back(v(I_SUB,0,0,NONE,0,OA,1)); vecs.push_back(v(I_SUB,0,1,NONE,0,OS,1));
    vecs.push_back(v(I_SUB,0,2,NONE,0,OS,1)); vecs.push_back(v(I_SUB,0,4,WB_R,0,OS,1));
    // lw, sw
    vecs.push_back(v(I_LW,0,0,NONE,0,OA,2));  vecs.push_back(v(I_LW,0,1,NONE,0,OA,2));
    vecs.push_back(v(I_LW,0,2,EX_I,0,OA,2));  vecs.push_back(v(I_LW,0,3,MEM_L,0,OA,2));
    vecs.push_back(v(I_LW,0,4,WB_L,0,OA,2));
    vecs.push_back(v(I_SW,0,0,NONE,0,OA,3));  vecs.push_back(v(I_SW,0,1,NONE,0,OA,3));
    vecs.push_back(v(I_SW,0,2,EX_I,0,OA,3));  vecs.push_back(v(I_SW,0,3,MEM_S,0,OA,3));
    // beq taken (zero also high outside EXEC, where it must be ignored), beq not taken
    vecs.push_back(v(I_BEQ,1,0,NONE,0,OA,4)); vecs.push_back(v(I_BEQ,1,1,NONE,0,OS,4));
    vecs.push_back(v(I_BEQ,1,2,RET,1,OS,4));
    vecs.push_back(v(I_BEQ,1,0,NONE,0,OA,5)); vecs.push_back(v(I_BEQ,1,1,NONE,0,OS,5));
    vecs.push_back(v(I_BEQ,0,2,RET,0,OS,5));
    // jal
    vecs.push_back(v(I_JAL,0,0,NONE,0,OA,6)); vecs.push_back(v(I_JAL,0,1,NONE,0,OA,6));
    vecs.push_back(v(I_JAL,0,2,EX_I,2,OA,6)); vecs.push_back(v(I_JAL,0,4,WB_J,2,OA,6));
    // ori with funct7[5] set (ignored for I-ALU)
    vecs.push_back(v(I_ORI,0,0,NONE,0,OA,7)); vecs.push_back(v(I_ORI,0,1,NONE,0,OO,7));
    vecs.push_back(v(I_ORI,0,2,EX_I,0,OO,7)); vecs.push_back(v(I_ORI,0,4,WB_J,0,OO,7));
    // and, slt
    vecs.push_back(v(I_AND,0,0,NONE,0,OA,8)); vecs.push_back(v(I_AND,0,1,NONE,0,ON,8));
    vecs.push_back(v(I_AND,0,2,NONE,0,ON,8)); vecs.push_back(v(I_AND,0,4,WB_R,0,ON,8));
    vecs.push_back(v(I_SLT,0,0,NONE,0,OA,9)); vecs.push_back(v(I_SLT,0,1,NONE,0,OL,9));
    vecs.push_back(v(I_SLT,0,2,NONE,0,OL,9)); vecs.push_back(v(I_SLT,0,4,WB_R,0,OL,9));
    // illegal word fetch
    vecs.push_back(v(I_ILL,0,0,NONE,0,OA,10));

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 0, 32'(act_m), 32'(pk(3'd0, 1'b0, NONE, 2'd0, OA)));
    chk("reset_icnt", 0, 32'(if_m.icount), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // DECODE of the illegal word: halting build stays quiet, NOP build retires
    @(negedge clk);
    chk("ill_dec_halt", 0, {29'd0, if_m.state}, 32'd1);
    chk("ill_dec_halt_pcw", 0, 32'(if_m.PCWrite), 32'd0);
    chk("ill_dec_nop_pcw", 0, 32'(if_n.PCWrite), 32'd1);
    chk("ill_dec_nop_pcs", 0, 32'(if_n.PCSrc), 32'd0);
    @(posedge clk);
    #1;
    ins  = I_ADD;
    @(negedge clk);
    chk("ill_nop_state", 0, 32'(if_n.state), 32'd0);
    chk("ill_nop_icnt", 0, 32'(if_n.icount), 32'd11);
    @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      zero = c[0];
      @(negedge clk);
      chk("halt_ctl", c, 32'(act_m), 32'(pk(3'd7, 1'b1, NONE, 2'd0, OA)));
      chk("halt_icnt", c, 32'(if_m.icount), 32'd10);
      @(posedge clk);
      #1;
    end
    zero = 1'b0;

    // async reset exits HALT
    rst_n = 1'b0;
    #2;
    chk("halt_reset", 0, 32'(act_m), 32'(pk(3'd0, 1'b0, NONE, 2'd0, OA)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ins = I_ADD;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_icnt", 0, 32'(if_m.icount), 32'd1);
    chk("pre_abort_state", 0, 32'(if_m.state), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    chk("abort_in_exec", 0, 32'(if_m.state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", 0, 32'(act_m), 32'(pk(3'd0, 1'b0, NONE, 2'd0, OA)));
    chk("abort_icnt", 0, 32'(if_m.icount), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_hold_ctl", 0, 32'(act_m), 32'(pk(3'd0, 1'b0, NONE, 2'd0, OA)));
    chk("abort_hold_icnt", 0, 32'(if_m.icount), 32'd0);
    rst_n = 1'b1;

`ifdef CTRL_STALL_EN
    // add stalled three cycles in WB, then released
    repeat (3) @(posedge clk);
    #1;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_ctl", c, 32'(act_m), 32'(pk(3'd4, 1'b0, NONE, 2'd0, OA)));
      chk("stall_icnt", c, 32'(if_m.icount), 32'd0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_ctl", 0, 32'(act_m), 32'(pk(3'd4, 1'b0, WB_R, 2'd0, OA)));
    @(posedge clk);
    @(negedge clk);
    chk("unstall_state", 0, 32'(if_m.state), 32'd0);
    chk("unstall_icnt", 0, 32'(if_m.icount), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
